// File: rtl/session_engine_if.sv
// Outbound request channel from session_engine to create_message.
// Valid/ready handshake: the request is transferred when msg_valid_o && msg_ready_i.
interface session_engine_if #(
  parameter int SESS_W = 3
);
  logic              msg_valid_o;
  logic              msg_ready_i;
  logic [3:0]        msg_type_o;
  logic [SESS_W-1:0] msg_host_o;

  modport master (output msg_valid_o, output msg_type_o, output msg_host_o, input msg_ready_i);
  modport slave  (input msg_valid_o, input msg_type_o, input msg_host_o, output msg_ready_i);
endinterface

// File: rtl/session_engine.sv
// FIX multi-session manager: per-session state, inactivity timer, resend retry count and
// one pending outbound request slot, with round-robin arbitration of outbound requests
// and of disconnect reports.
module session_engine #(
  parameter int SESS_W      = 3,
  parameter int TMR_W       = 16,
  parameter int HB_INTERVAL = 1000,
  parameter int MAX_RESEND  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_message_i,
  input  logic [SESS_W-1:0] host_i,
  input  logic [3:0]        type_i,
  input  logic [2:0]        validity_i,
  input  logic              resend_done_i,
  input  logic              connected_i,
  input  logic              end_session_i,
  input  logic [SESS_W-1:0] ctl_host_i,
  session_engine_if.master  msg_if,
  output logic              deliver_o,
  output logic              seq_update_o,
  output logic              ignore_o,
  output logic              disconnect_o,
  output logic [SESS_W-1:0] disconnect_host_o,
  output logic [2:0]        error_type_o
);
  localparam int NUM_SESS = 1 << SESS_W;
  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam logic [TMR_W-1:0] HB_CNT  = TMR_W'(HB_INTERVAL);

  localparam logic [3:0] T_LOGON = 4'd1, T_HB = 4'd2, T_RESEND = 4'd3, T_LOGOUT = 4'd4;
  localparam logic [3:0] T_RESET = 4'd5, T_GAPFILL = 4'd6, T_BUSINESS = 4'd7;
  localparam logic [2:0] V_VALID = 3'b000, V_HIGH = 3'b001, V_GARBLED = 3'b010;
  localparam logic [2:0] V_LOW = 3'b011, V_INVALID = 3'b100;

  typedef enum logic [2:0] {
    S_DISC, S_LOGON_SENT, S_ACTIVE, S_HB_SENT, S_RESEND, S_RESEND_LOGOUT, S_LOGOUT_SENT
  } state_e;

  // Outbound priority: logout > resendReq > logon > heartbeat.
  function automatic logic [1:0] prio(input logic [3:0] t);
    case (t)
      T_LOGOUT: prio = 2'd3;
      T_RESEND: prio = 2'd2;
      T_LOGON:  prio = 2'd1;
      default:  prio = 2'd0;
    endcase
  endfunction

  state_e            st_q    [NUM_SESS];
  state_e            st_d    [NUM_SESS];
  logic [TMR_W-1:0]  tmr_q   [NUM_SESS];
  logic [TMR_W-1:0]  tmr_d   [NUM_SESS];
  logic [2:0]        retry_q [NUM_SESS];
  logic [2:0]        retry_d [NUM_SESS];
  logic [3:0]        ptype_q [NUM_SESS];
  logic [3:0]        ptype_d [NUM_SESS];
  logic [2:0]        derr_q  [NUM_SESS];
  logic [2:0]        derr_d  [NUM_SESS];
  logic [3:0]        req_t   [NUM_SESS];
  logic [2:0]        kerr    [NUM_SESS];
  logic [NUM_SESS-1:0] pend_q, pend_d, dpend_q, dpend_d;
  logic [NUM_SESS-1:0] ctl_hit, inb_hit, expired, req_v, kill;

  logic              msg_valid_q, msg_valid_d;
  logic [3:0]        msg_type_q, msg_type_d;
  logic [SESS_W-1:0] msg_host_q, msg_host_d, last_q, last_d, cand;
  logic              disc_q, disc_d;
  logic [SESS_W-1:0] disc_host_q, disc_host_d, dlast_q, dlast_d;
  logic [2:0]        disc_err_q, disc_err_d;
  logic              deliver_q, deliver_d, sequp_q, sequp_d, ignore_q, ignore_d;
  logic              gfound, dfound;

  wire fatal_w   = (validity_i == V_LOW) || (validity_i == V_INVALID);
  wire garbled_w = (validity_i == V_GARBLED);
  wire high_w    = (validity_i == V_HIGH);
  wire valid_w   = (validity_i == V_VALID);

  // Per-session event decode: control hit, inbound hit, inactivity expiry.
  always_comb begin
    for (int s = 0; s < NUM_SESS; s++) begin
      ctl_hit[s] = (connected_i || end_session_i) && (ctl_host_i == SESS_W'(s));
      inb_hit[s] = new_message_i && (host_i == SESS_W'(s));
      expired[s] = (st_q[s] != S_DISC) && (tmr_q[s] >= HB_CNT);
    end
  end

  // Session next state: control beats inbound, inbound beats timer expiry.
  always_comb begin
    deliver_d = 1'b0;
    sequp_d   = 1'b0;
    ignore_d  = 1'b0;
    for (int s = 0; s < NUM_SESS; s++) begin
      st_d[s]    = st_q[s];
      retry_d[s] = retry_q[s];
      tmr_d[s]   = (st_q[s] != S_DISC && tmr_q[s] != TMR_MAX) ? tmr_q[s] + 1'b1 : tmr_q[s];
      req_v[s]   = 1'b0;
      req_t[s]   = T_HB;
      kill[s]    = 1'b0;
      kerr[s]    = 3'b000;
      if (ctl_hit[s]) begin
        if (inb_hit[s]) ignore_d = 1'b1;
        if (connected_i) begin
          req_v[s] = 1'b1; req_t[s] = T_LOGON; st_d[s] = S_LOGON_SENT; tmr_d[s] = '0;
        end else if (st_q[s] != S_DISC) begin
          req_v[s] = 1'b1; req_t[s] = T_LOGOUT; st_d[s] = S_LOGOUT_SENT; tmr_d[s] = '0;
        end
      end else if (inb_hit[s] && st_q[s] == S_DISC) begin
        ignore_d = 1'b1;
      end else if (inb_hit[s] && fatal_w) begin
        kill[s] = 1'b1; kerr[s] = 3'b001;
      end else if (inb_hit[s] && !garbled_w) begin
        tmr_d[s] = '0;
        case (st_q[s])
          S_LOGON_SENT: begin
            if (type_i == T_LOGON && valid_w) st_d[s] = S_ACTIVE;
            else if (type_i == T_LOGON && high_w) begin
              st_d[s] = S_RESEND; req_v[s] = 1'b1; req_t[s] = T_RESEND;
            end else kill[s] = 1'b1;
          end
          S_ACTIVE, S_HB_SENT: begin
            if (type_i == T_LOGOUT && valid_w) begin
              st_d[s] = S_DISC; req_v[s] = 1'b1; req_t[s] = T_LOGOUT;
            end else if (type_i == T_LOGOUT && high_w) begin
              st_d[s] = S_RESEND_LOGOUT; req_v[s] = 1'b1; req_t[s] = T_RESEND;
            end else if (type_i == T_RESEND) begin
              st_d[s] = S_ACTIVE; req_v[s] = 1'b1; req_t[s] = T_HB;
            end else if (high_w) begin
              st_d[s] = S_RESEND; req_v[s] = 1'b1; req_t[s] = T_RESEND;
            end else begin
              st_d[s] = S_ACTIVE;
              deliver_d = (type_i == T_BUSINESS);
            end
          end
          S_RESEND, S_RESEND_LOGOUT: begin
            sequp_d = (type_i == T_GAPFILL) || (type_i == T_RESET);
            if (resend_done_i) begin
              retry_d[s] = '0;
              if (st_q[s] == S_RESEND) st_d[s] = S_ACTIVE;
              else begin
                st_d[s] = S_LOGOUT_SENT; req_v[s] = 1'b1; req_t[s] = T_LOGOUT;
              end
            end else if (high_w && type_i != T_RESET) begin
              req_v[s] = 1'b1; req_t[s] = T_RESEND;
            end
          end
          S_LOGOUT_SENT: begin
            if (type_i == T_RESEND) begin
              req_v[s] = 1'b1; req_t[s] = T_HB;
            end else kill[s] = 1'b1;
          end
          default: ;
        endcase
      end else begin
        // Garbled traffic is dropped without touching the timer, so expiry still applies.
        if (inb_hit[s]) ignore_d = 1'b1;
        if (expired[s]) begin
          case (st_q[s])
            S_ACTIVE: begin
              req_v[s] = 1'b1; req_t[s] = T_HB; st_d[s] = S_HB_SENT; tmr_d[s] = '0;
            end
            S_RESEND, S_RESEND_LOGOUT: begin
              if (int'(retry_q[s]) + 1 < MAX_RESEND) begin
                retry_d[s] = retry_q[s] + 3'd1;
                req_v[s] = 1'b1; req_t[s] = T_RESEND; tmr_d[s] = '0;
              end else begin
                kill[s] = 1'b1; kerr[s] = 3'b010;
              end
            end
            default: kill[s] = 1'b1;
          endcase
        end
      end
      if (kill[s]) begin
        st_d[s] = S_DISC; tmr_d[s] = '0;
      end
      if (st_d[s] == S_DISC) retry_d[s] = '0;
    end
  end

  // Pending slots, outbound arbiter and disconnect reporter.
  always_comb begin
    pend_d  = pend_q;
    dpend_d = dpend_q;
    for (int s = 0; s < NUM_SESS; s++) begin
      ptype_d[s] = ptype_q[s];
      derr_d[s]  = derr_q[s];
      if (kill[s]) begin
        pend_d[s] = 1'b0; dpend_d[s] = 1'b1; derr_d[s] = kerr[s];
      end else if (req_v[s] && (!pend_q[s] || prio(req_t[s]) > prio(ptype_q[s]))) begin
        pend_d[s] = 1'b1; ptype_d[s] = req_t[s];
      end
    end
    // A presented request is held until accepted; only then may a new one be loaded.
    msg_valid_d = msg_valid_q && !msg_if.msg_ready_i;
    msg_type_d  = msg_type_q;
    msg_host_d  = msg_host_q;
    last_d      = last_q;
    gfound      = 1'b0;
    cand        = '0;
    if (!msg_valid_q || msg_if.msg_ready_i) begin
      for (int i = 1; i <= NUM_SESS; i++) begin
        cand = last_q + SESS_W'(i);
        if (!gfound && pend_d[cand]) begin
          gfound      = 1'b1;
          msg_valid_d = 1'b1;
          msg_type_d  = ptype_d[cand];
          msg_host_d  = cand;
          last_d      = cand;
          pend_d[cand] = 1'b0;
        end
      end
    end
    disc_d      = 1'b0;
    disc_host_d = '0;
    disc_err_d  = 3'b000;
    dlast_d     = dlast_q;
    dfound      = 1'b0;
    for (int i = 1; i <= NUM_SESS; i++) begin
      cand = dlast_q + SESS_W'(i);
      if (!dfound && dpend_d[cand]) begin
        dfound      = 1'b1;
        disc_d      = 1'b1;
        disc_host_d = cand;
        disc_err_d  = derr_d[cand];
        dlast_d     = cand;
        dpend_d[cand] = 1'b0;
      end
    end
  end

  // State registers; reset clears every session, the queue and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SESS; s++) begin
        st_q[s] <= S_DISC; tmr_q[s] <= '0; retry_q[s] <= '0;
        ptype_q[s] <= '0; derr_q[s] <= '0;
      end
      pend_q <= '0; dpend_q <= '0;
      msg_valid_q <= 1'b0; msg_type_q <= '0; msg_host_q <= '0; last_q <= '1;
      disc_q <= 1'b0; disc_host_q <= '0; disc_err_q <= '0; dlast_q <= '1;
      deliver_q <= 1'b0; sequp_q <= 1'b0; ignore_q <= 1'b0;
    end else begin
      st_q <= st_d; tmr_q <= tmr_d; retry_q <= retry_d;
      ptype_q <= ptype_d; derr_q <= derr_d;
      pend_q <= pend_d; dpend_q <= dpend_d;
      msg_valid_q <= msg_valid_d; msg_type_q <= msg_type_d; msg_host_q <= msg_host_d;
      last_q <= last_d;
      disc_q <= disc_d; disc_host_q <= disc_host_d; disc_err_q <= disc_err_d;
      dlast_q <= dlast_d;
      deliver_q <= deliver_d; sequp_q <= sequp_d; ignore_q <= ignore_d;
    end
  end

  assign msg_if.msg_valid_o = msg_valid_q;
  assign msg_if.msg_type_o  = msg_type_q;
  assign msg_if.msg_host_o  = msg_host_q;
  assign deliver_o          = deliver_q;
  assign seq_update_o       = sequp_q;
  assign ignore_o           = ignore_q;
  assign disconnect_o       = disc_q;
  assign disconnect_host_o  = disc_host_q;
  assign error_type_o       = disc_err_q;
endmodule

// File: tb/tb_session_engine.sv
// Directed and randomized bench for session_engine with an in-bench reference of the
// session rules (expected latencies, grant order, delivery/ignore decisions).
module tb_session_engine;
  localparam int SESS_W = 3;
  localparam int TMR_W  = 16;
  localparam int HB     = 1000;
  localparam int MAXR   = 3;

  logic clk = 1'b0;
  logic rst, new_message_i, resend_done_i, connected_i, end_session_i;
  logic [SESS_W-1:0] host_i, ctl_host_i;
  logic [3:0] type_i;
  logic [2:0] validity_i;
  logic deliver_o, seq_update_o, ignore_o, disconnect_o;
  logic [SESS_W-1:0] disconnect_host_o;
  logic [2:0] error_type_o;

  session_engine_if #(.SESS_W(SESS_W)) mif ();

  session_engine #(.SESS_W(SESS_W), .TMR_W(TMR_W), .HB_INTERVAL(HB), .MAX_RESEND(MAXR)) dut (
    .clk(clk), .rst(rst), .new_message_i(new_message_i), .host_i(host_i), .type_i(type_i),
    .validity_i(validity_i), .resend_done_i(resend_done_i), .connected_i(connected_i),
    .end_session_i(end_session_i), .ctl_host_i(ctl_host_i), .msg_if(mif),
    .deliver_o(deliver_o), .seq_update_o(seq_update_o), .ignore_o(ignore_o),
    .disconnect_o(disconnect_o), .disconnect_host_o(disconnect_host_o),
    .error_type_o(error_type_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    new_message_i = 1'b0; connected_i = 1'b0; end_session_i = 1'b0; resend_done_i = 1'b0;
  endtask

  task automatic send(input int h, input int t, input int v);
    new_message_i = 1'b1; host_i = SESS_W'(h); type_i = 4'(t); validity_i = 3'(v);
    tick();
    new_message_i = 1'b0;
  endtask

  task automatic ctl(input int h, input logic conn, input logic ends);
    ctl_host_i = SESS_W'(h); connected_i = conn; end_session_i = ends;
    tick();
    connected_i = 1'b0; end_session_i = 1'b0;
  endtask

  task automatic chk_msg(input string tag, input int v, input int t, input int h);
    chk({tag, "_valid"}, int'(mif.msg_valid_o), v);
    chk({tag, "_type"},  int'(mif.msg_type_o), t);
    chk({tag, "_host"},  int'(mif.msg_host_o), h);
  endtask

  task automatic chk_disc(input string tag, input int h, input int e);
    chk({tag, "_pulse"}, int'(disconnect_o), 1);
    chk({tag, "_host"},  int'(disconnect_host_o), h);
    chk({tag, "_err"},   int'(error_type_o), e);
  endtask

  // Ticks until msg_valid_o (or disconnect_o) shows; the bound counts as elapsed cycles.
  task automatic wait_event(input bit want_disc, output int n);
    n = 0;
    while (n < HB + 50 && !(want_disc ? disconnect_o : mif.msg_valid_o)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, rcount, dhost, derr;
    bit nm, got, seen, exp_del, exp_ign;
    int h, t, v;

    rst = 1'b1; idle(); mif.msg_ready_i = 1'b1;
    host_i = '0; type_i = '0; validity_i = '0; ctl_host_i = '0;
    repeat (3) tick();
    chk_msg("reset_msg", 0, 0, 0);
    chk("reset_deliver", int'(deliver_o), 0);
    chk("reset_sequp", int'(seq_update_o), 0);
    chk("reset_ignore", int'(ignore_o), 0);
    chk("reset_disc", int'(disconnect_o), 0);
    chk("reset_err", int'(error_type_o), 0);
    rst = 1'b0;
    tick();

    // Logon, heartbeat after HB idle cycles, disconnect after HB more.
    ctl(2, 1'b1, 1'b0);
    chk_msg("logon2", 1, 1, 2);
    send(2, 1, 0);
    chk("logon2_ignore", int'(ignore_o), 0);
    chk("logon2_accepted", int'(mif.msg_valid_o), 0);
    wait_event(1'b0, n);
    chk("hb2_delay", n, HB + 1);
    chk_msg("hb2", 1, 2, 2);
    wait_event(1'b1, n);
    chk("hbto2_delay", n, HB + 1);
    chk_disc("hbto2", 2, 0);

    // Random inbound traffic on two ACTIVE sessions.
    ctl(0, 1'b1, 1'b0); send(0, 1, 0); ctl(1, 1'b1, 1'b0); send(1, 1, 0);
    chk("rand_pre_valid", int'(mif.msg_valid_o), 0);
    for (int i = 0; i < 150; i++) begin
      nm = ($urandom_range(0, 3) != 0);
      h  = int'($urandom_range(0, 1));
      t  = ($urandom_range(0, 1) != 0) ? 7 : 2;
      v  = ($urandom_range(0, 1) != 0) ? 2 : 0;
      new_message_i = nm; host_i = SESS_W'(h); type_i = 4'(t); validity_i = 3'(v);
      tick();
      new_message_i = 1'b0;
      exp_del = nm && t == 7 && v == 0;
      exp_ign = nm && v == 2;
      chk("rand_deliver", int'(deliver_o), int'(exp_del));
      chk("rand_ignore", int'(ignore_o), int'(exp_ign));
      chk("rand_msg_valid", int'(mif.msg_valid_o), 0);
    end

    // Control and inbound on the same session in one cycle: control wins.
    end_session_i = 1'b1; ctl_host_i = 3'd0;
    new_message_i = 1'b1; host_i = 3'd0; type_i = 4'd7; validity_i = 3'd0;
    tick();
    idle();
    chk_msg("coll_logout0", 1, 4, 0);
    chk("coll_ignore", int'(ignore_o), 1);
    chk("coll_deliver", int'(deliver_o), 0);
    ctl(1, 1'b0, 1'b1);
    chk_msg("logout1", 1, 4, 1);
    send(0, 4, 0);
    chk_disc("lo0", 0, 0);
    send(1, 4, 0);
    chk_disc("lo1", 1, 0);

    // Stalled channel: priority overwrite and round-robin grant order.
    mif.msg_ready_i = 1'b0;
    ctl(0, 1'b1, 1'b0);
    chk_msg("stall_first", 1, 1, 0);
    ctl(1, 1'b1, 1'b0);
    chk_msg("stall_a", 1, 1, 0);
    ctl(5, 1'b1, 1'b0);
    chk_msg("stall_b", 1, 1, 0);
    ctl(1, 1'b0, 1'b1);
    chk_msg("stall_c", 1, 1, 0);
    mif.msg_ready_i = 1'b1;
    tick();
    chk_msg("grant1", 1, 4, 1);
    tick();
    chk_msg("grant2", 1, 1, 5);
    tick();
    chk("grant_done", int'(mif.msg_valid_o), 0);
    send(5, 2, 0); chk_disc("clr5", 5, 0);
    send(0, 2, 0); chk_disc("clr0", 0, 0);
    send(1, 2, 0); chk_disc("clr1", 1, 0);

    // Resend retries exhausted.
    ctl(3, 1'b1, 1'b0); send(3, 1, 0);
    send(3, 7, 1);
    chk_msg("rs3_first", 1, 3, 3);
    chk("rs3_deliver", int'(deliver_o), 0);
    send(3, 6, 0);
    chk("rs3_sequp", int'(seq_update_o), 1);
    rcount = 1; got = 1'b0; dhost = -1; derr = -1;
    for (int i = 0; i < 3 * (HB + 1) + 20; i++) begin
      tick();
      if (mif.msg_valid_o && mif.msg_host_o == 3'd3 && mif.msg_type_o == 4'd3) rcount++;
      if (disconnect_o) begin
        got = 1'b1; dhost = int'(disconnect_host_o); derr = int'(error_type_o);
        break;
      end
    end
    chk("rs3_count", rcount, MAXR);
    chk("rs3_disc_seen", int'(got), 1);
    chk("rs3_disc_host", dhost, 3);
    chk("rs3_disc_err", derr, 2);

    // Fatal inbound on host4 in the same cycle host6 times out.
    ctl(6, 1'b1, 1'b0);
    ctl(4, 1'b1, 1'b0);
    send(4, 1, 0);
    repeat (HB - 2) tick();
    send(4, 7, 3);
    chk_disc("fatal4", 4, 1);
    tick();
    chk_disc("to6", 6, 0);
    tick();
    chk("disc_quiet", int'(disconnect_o), 0);

    // Reset in the middle of a stalled handshake.
    mif.msg_ready_i = 1'b0;
    ctl(7, 1'b1, 1'b0);
    chk("rstmid_pre", int'(mif.msg_valid_o), 1);
    rst = 1'b1;
    tick();
    chk_msg("rstmid", 0, 0, 0);
    chk("rstmid_disc", int'(disconnect_o), 0);
    rst = 1'b0;
    mif.msg_ready_i = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (mif.msg_valid_o || disconnect_o) seen = 1'b1;
    end
    chk("rstmid_after", int'(seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
